// File: rtl/fft_pkg.sv
// Shared helpers for the FFT datapath: complex packing positions, index
// bit-reversal and a constant log2 for sizing.
package fft_pkg;

    // Number of bits needed to index n items (n >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int v = 32'sd1; v < n; v = v * 32'sd2) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Reverse the low nbits bits of idx.
    function automatic int bitrev(input int idx, input int nbits);
        int r;
        r = 32'sd0;
        for (int b = 32'sd0; b < nbits; b++) begin
            if (((idx >> b) & 32'sd1) != 32'sd0) begin
                r = r | (32'sd1 << (nbits - 32'sd1 - b));
            end
        end
        return r;
    endfunction

    // LSB position of the real component of element k (real sits in the upper half).
    function automatic int re_lsb(input int k, input int dw);
        return (32'sd2 * k + 32'sd1) * dw;
    endfunction

    // LSB position of the imaginary component of element k.
    function automatic int im_lsb(input int k, input int dw);
        return 32'sd2 * k * dw;
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Combinational radix-2 butterfly without twiddle. Outputs carry one extra
// bit so neither the sum nor the difference can overflow.
import fft_pkg::*;

module fft_bfly2 #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a_re,
    input  logic [DW-1:0] i_a_im,
    input  logic [DW-1:0] i_b_re,
    input  logic [DW-1:0] i_b_im,
    output logic [DW:0]   o_sum_re,
    output logic [DW:0]   o_sum_im,
    output logic [DW:0]   o_dif_re,
    output logic [DW:0]   o_dif_im
);

    logic [DW:0] w_a_re;
    logic [DW:0] w_a_im;
    logic [DW:0] w_b_re;
    logic [DW:0] w_b_im;

    // Sign-extend operands by one bit before add/sub.
    always_comb begin
        w_a_re = {i_a_re[DW-1], i_a_re};
        w_a_im = {i_a_im[DW-1], i_a_im};
        w_b_re = {i_b_re[DW-1], i_b_re};
        w_b_im = {i_b_im[DW-1], i_b_im};
    end

    // Sum and difference, real and imaginary handled independently.
    always_comb begin
        o_sum_re = w_a_re + w_b_re;
        o_sum_im = w_a_im + w_b_im;
        o_dif_re = w_a_re - w_b_re;
        o_dif_im = w_a_im - w_b_im;
    end

endmodule

// File: rtl/fft_bfly_last_stage_pipe.sv
// Final radix-2 FFT butterfly stage, two-register pipeline with valid/ready.
// S1 holds the full-precision butterfly results, S2 the narrowed, shifted
// and optionally bit-reversed frame.
// Build option: FFT_BFLY_SAT_EN selects saturating narrowing; without it the
// narrowing wraps (legacy behaviour). Overflow is flagged either way.
import fft_pkg::*;

module fft_bfly_last_stage_pipe #(
    parameter int N_POINTS  = 16,
    parameter int DW        = 16,
    parameter int OUT_SHIFT = 4,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_POINTS*2*DW-1:0]    in_data,
    input  logic                        bitrev_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_POINTS*2*DW-1:0]    out_data,
    output logic [CNT_W-1:0]            frame_cnt,
    output logic                        ovf_flag
);

    localparam int LOG2N = clog2(N_POINTS);
    localparam int FW    = N_POINTS * 2 * DW;

    // Butterfly outputs, full precision
    logic [DW:0]            w_bf_re  [N_POINTS];
    logic [DW:0]            w_bf_im  [N_POINTS];

    // Stage 1 registers
    logic                   r_s1_valid;
    logic                   r_s1_bitrev;
    logic [DW:0]            r_s1_re  [N_POINTS];
    logic [DW:0]            r_s1_im  [N_POINTS];

    // Narrowed/shifted results in natural order, and the reordered frame
    logic [DW-1:0]          w_sc_re  [N_POINTS];
    logic [DW-1:0]          w_sc_im  [N_POINTS];
    logic [2*N_POINTS-1:0]  w_ovf;
    logic [FW-1:0]          w_s2_data;

    // Stage 2 registers and status
    logic                   r_s2_valid;
    logic [FW-1:0]          r_s2_data;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_ovf;

    logic                   w_s1_ready;
    logic                   w_s2_ready;

    // Pipeline flow control: a stage may load when empty or when it drains this cycle.
    always_comb begin
        w_s2_ready = !r_s2_valid || out_ready;
        w_s1_ready = !r_s1_valid || w_s2_ready;
    end

    // Adjacent-pair butterflies (2m, 2m+1)
    for (genvar m = 0; m < N_POINTS / 2; m++) begin : g_bfly
        fft_bfly2 #(.DW(DW)) u_bfly2 (
            .i_a_re   (in_data[re_lsb(2*m,   DW) +: DW]),
            .i_a_im   (in_data[im_lsb(2*m,   DW) +: DW]),
            .i_b_re   (in_data[re_lsb(2*m+1, DW) +: DW]),
            .i_b_im   (in_data[im_lsb(2*m+1, DW) +: DW]),
            .o_sum_re (w_bf_re[2*m]),
            .o_sum_im (w_bf_im[2*m]),
            .o_dif_re (w_bf_re[2*m+1]),
            .o_dif_im (w_bf_im[2*m+1])
        );
    end

    // S1: capture butterfly results and the ordering mode on the input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_bitrev <= 1'b0;
            for (int k = 0; k < N_POINTS; k++) begin
                r_s1_re[k] <= '0;
                r_s1_im[k] <= '0;
            end
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_bitrev <= bitrev_en;
                for (int k = 0; k < N_POINTS; k++) begin
                    r_s1_re[k] <= w_bf_re[k];
                    r_s1_im[k] <= w_bf_im[k];
                end
            end
        end
    end

    // Narrow to DW bits, then arithmetic shift (floor) with sign replication.
    for (genvar k = 0; k < N_POINTS; k++) begin : g_scale
        logic [DW-1:0] w_nar_re;
        logic [DW-1:0] w_nar_im;

        // A (DW+1)-bit value fits in DW bits only if its top two bits agree.
        assign w_ovf[2*k]   = r_s1_re[k][DW] ^ r_s1_re[k][DW-1];
        assign w_ovf[2*k+1] = r_s1_im[k][DW] ^ r_s1_im[k][DW-1];

`ifdef FFT_BFLY_SAT_EN
        localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
        localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
        assign w_nar_re = w_ovf[2*k]   ? (r_s1_re[k][DW] ? SAT_MIN : SAT_MAX) : r_s1_re[k][DW-1:0];
        assign w_nar_im = w_ovf[2*k+1] ? (r_s1_im[k][DW] ? SAT_MIN : SAT_MAX) : r_s1_im[k][DW-1:0];
`else
        assign w_nar_re = r_s1_re[k][DW-1:0];
        assign w_nar_im = r_s1_im[k][DW-1:0];
`endif

        assign w_sc_re[k] = $signed(w_nar_re) >>> OUT_SHIFT;
        assign w_sc_im[k] = $signed(w_nar_im) >>> OUT_SHIFT;
    end

    // Reorder: bit reversal is its own inverse, so output g reads result bitrev(g).
    for (genvar g = 0; g < N_POINTS; g++) begin : g_order
        localparam int SRC = bitrev(g, LOG2N);
        assign w_s2_data[re_lsb(g, DW) +: DW] = r_s1_bitrev ? w_sc_re[SRC] : w_sc_re[g];
        assign w_s2_data[im_lsb(g, DW) +: DW] = r_s1_bitrev ? w_sc_im[SRC] : w_sc_im[g];
    end

    // S2: take the processed frame whenever S2 is free or draining; hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
        end
    end

    // Sticky overflow, evaluated as a frame moves from S1 into S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_s1_valid && w_s2_ready && (|w_ovf)) begin
            r_ovf <= 1'b1;
        end
    end

    // Delivered-frame counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign frame_cnt = r_frame_cnt;
    assign ovf_flag  = r_ovf;

endmodule
